// File: rtl/bi_dir_bus_ctrl.sv
// Clocked direction controller for a shared bidirectional bus with a guaranteed hi-Z turnaround gap.
// Optional even-parity sideband on the bus is built when BI_DIR_BUS_PARITY_EN is defined.
module bi_dir_bus_ctrl #(
  parameter int WIDTH      = 32,
  parameter int TURNAROUND = 2
) (
  input  logic             clock,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] data_to_from_bus,
  input  logic             send_data,
  input  logic             rcv_data,
  input  logic [WIDTH-1:0] ckt_to_bus,
  input  logic             ckt_valid,
  output logic             ckt_ready,
  input  logic             bus_strobe,
  output logic [WIDTH-1:0] data_from_bus,
  output logic             rcv_valid,
  output logic             bus_oe,
`ifdef BI_DIR_BUS_PARITY_EN
  inout  wire              parity_to_from_bus,
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(TURNAROUND + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURNAROUND - 1);

  // DRIVE differs from IDLE in a single bit so the async reset cannot glitch bus_oe high
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DRIVE   = 2'b01,
    ST_TURN    = 2'b10,
    ST_RECEIVE = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] tx_r;
  logic [WIDTH-1:0] rx_r;
  logic             rx_valid_r;
  logic             tx_load_s;
  logic             rx_cap_s;
  logic             drive_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  // Next-state and turnaround counter decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (rcv_data) begin
          state_nxt_s = ST_RECEIVE;
        end else if (send_data) begin
          state_nxt_s = ST_DRIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (!send_data) begin
          state_nxt_s = ST_TURN;
          cnt_nxt_s   = TURN_LOAD;
        end else begin
          state_nxt_s = ST_DRIVE;
        end
      end
      ST_TURN: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RECEIVE: begin
        if (!rcv_data) begin
          state_nxt_s = ST_TURN;
          cnt_nxt_s   = TURN_LOAD;
        end else begin
          state_nxt_s = ST_RECEIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Transmit load and receive capture qualifiers
  always_comb begin
    drive_s   = (state_r == ST_DRIVE);
    tx_load_s = drive_s && ckt_valid;
    rx_cap_s  = (state_r == ST_RECEIVE) && bus_strobe;
  end

  // State and counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Transmit register; holds its word across TURN/IDLE for the next DRIVE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_r <= {WIDTH{1'b0}};
    end else if (tx_load_s) begin
      tx_r <= ckt_to_bus;
    end else begin
      tx_r <= tx_r;
    end
  end

  // Strobe-qualified receive register and one-cycle valid pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_r       <= {WIDTH{1'b0}};
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= rx_cap_s;
      if (rx_cap_s) begin
        rx_r <= data_to_from_bus;
      end else begin
        rx_r <= rx_r;
      end
    end
  end

  assign bus_oe           = drive_s;
  assign busy             = (state_r != ST_IDLE);
  assign ckt_ready        = drive_s;
  assign data_from_bus    = rx_r;
  assign rcv_valid        = rx_valid_r;
  assign data_to_from_bus = drive_s ? tx_r : {WIDTH{1'bz}};

`ifdef BI_DIR_BUS_PARITY_EN
  logic parity_err_r;

  // Parity check result, refreshed once per captured word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity_err_r <= 1'b0;
    end else if (rx_cap_s) begin
      parity_err_r <= even_parity(data_to_from_bus) ^ parity_to_from_bus;
    end else begin
      parity_err_r <= parity_err_r;
    end
  end

  assign parity_err         = parity_err_r;
  assign parity_to_from_bus = drive_s ? even_parity(tx_r) : 1'bz;
`endif

endmodule
